spi_flash_page_writer: RTL and testbench
========================================

// Module: spi_flash_page_writer
// PURPOSE
// - SPI flash programming master; the write-direction counterpart of the boot-time 0x03 flash reader.
// - Issues WREN 0x06, then Page Program 0x02 + 24-bit address + 1..256 streamed bytes.
// - Then polls Read Status 0x05 until WIP (bit 0) clears.
// - Sits between a byte source (UART loader, cache dump) and the flash_clk/mosi/miso/cs pins.
// PARAMETERS
// - CLK_DIV     2        system clocks per SPI clock half-period (>=1)
// - CS_GAP      4        system clocks flash_cs held high between commands
// - POLL_MAX    2000000  status polls before timeout error
// PORTS
// - clk          in   1   system clock; all logic on posedge
// - rst          in   1   asynchronous reset, active-high
// - start        in   1   one-cycle request; sampled only in IDLE
// - erase        in   1   with start: sector erase 0x20 instead of program (macro only)
// - address      in   24  flash byte address; latched on accepted start
// - length       in   9   page-program byte count, 1..256; latched on start
// - data_in      in   8   next byte to program
// - data_valid   in   1   data_in valid
// - data_ready   out  1   byte consumed this cycle (valid & ready = transfer)
// - busy         out  1   high from accepted start through done/error
// - done         out  1   one-cycle pulse: operation finished, WIP clear
// - error        out  1   one-cycle pulse: rejected request or poll timeout
// - flash_clk    out  1   SPI clock, mode 0, idles low
// - flash_mosi   out  1   changes while flash_clk low, MSB first
// - flash_miso   in   1   sampled on flash_clk rising edge
// - flash_cs     out  1   chip select, active-low
// BEHAVIOUR
// - Reset values:
//   - flash_cs=1, flash_clk=0, flash_mosi=0.
//   - busy=done=error=data_ready=0; state IDLE.
// - Reset mid-operation: cs deasserts asynchronously. Flash may be left mid-program; caller re-polls.
// - States:
//   - IDLE -> WREN -> GAP -> CMD(0x02) -> ADDR -> DATA -> GAP -> RDSR_CMD -> RDSR_READ -> DONE -> IDLE.
//   - GAP: cs high CS_GAP clocks.
//   - RDSR_READ: 8 bits read per poll, cs kept low, repeats while bit0=1.
// - Start validation in IDLE:
//   - length==0, length>256, or address[7:0]+length>256 (page wrap) -> error pulse next cycle.
//   - Nothing driven on the pins; stays IDLE.
// - start while busy is ignored (no error).
// - DATA state:
//   - data_ready pulses exactly once per byte, in the cycle the byte is loaded into the shifter.
//   - If data_valid is low: flash_clk holds low, cs stays low, no timeout.
// - Bit timing: each bit = CLK_DIV clocks low + CLK_DIV clocks high.
//   - Byte = 16*CLK_DIV clocks.
//   - cs falls >= CLK_DIV clocks before the first rising edge.
// - Byte counter 9-bit; DATA exits after `length` bytes. Address register is not incremented.
// - Poll counter saturates at POLL_MAX -> cs high, error pulse, IDLE.
// - done and error are never asserted together. busy drops in the same cycle as done/error.
// CONFIGURATION
// - FLASH_WRITER_ERASE_EN defined:
//   - start with erase=1 runs WREN, GAP, 0x20 + address[23:12]<<12, GAP, status poll, done.
//   - length and data ports ignored; no page-wrap check.
// - Not defined: erase input is unused, 0x20 never emitted, start always programs.
// STRUCTURE
// - Package flash_writer_pkg:
//   - opcodes OP_WREN=8'h06, OP_PP=8'h02, OP_RDSR=8'h05, OP_SE=8'h20.
//   - state_t enum; PAGE_BYTES=256.
// - Sub-module spi_byte_shifter:
//   - load/byte_out/byte_in/byte_done, owns flash_clk, mosi and the CLK_DIV divider.
//   - Top FSM sequences bytes and cs only.
// TESTING (bench with a behavioural SPI flash model, CLK_DIV=2)
// - Program 0x000100, length 4, bytes 31 32 33 34:
//   - pins carry 06 | 02 00 01 00 31 32 33 34 | 05...
//   - model memory holds 34_33_32_31 as a 32-bit word; one done pulse.
// - Model WIP=1 for 3 polls:
//   - exactly 4 status bytes read under one cs-low window, then done.
// - address 0x0000F0, length 32 -> error pulse, flash_cs never falls.
// - length 0 -> error. length 256 at 0x000000 -> 256 data_ready pulses, done.
// - data_valid dropped 100 clocks mid-page:
//   - flash_clk frozen low, cs low; data correct after resume.
// - rst asserted during DATA: flash_cs=1 same cycle; next start runs normally.
//   - With FLASH_WRITER_ERASE_EN: erase at 0x012345 emits 06 | 20 01 20 00 | 05.

Source files
------------

// File: rtl/flash_writer_pkg.sv
// Shared opcodes, FSM state encoding and page-fit check for the SPI flash page writer.
package flash_writer_pkg;

    localparam logic [7:0] OP_WREN = 8'h06;
    localparam logic [7:0] OP_PP   = 8'h02;
    localparam logic [7:0] OP_RDSR = 8'h05;
    localparam logic [7:0] OP_SE   = 8'h20;

    localparam int PAGE_BYTES = 256;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WREN,
        S_GAP,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_RDSR_CMD,
        S_RDSR_READ,
        S_DONE
    } state_t;

    // A program burst must stay inside one page; the flash would wrap otherwise.
    function automatic logic page_fits(input logic [7:0] offset, input logic [8:0] len);
        logic [9:0] span;
        span = {2'b00, offset} + {1'b0, len};
        return (len != 9'd0) && (len <= 9'(PAGE_BYTES)) && (span <= 10'(PAGE_BYTES));
    endfunction

endpackage

// File: rtl/spi_byte_shifter.sv
// SPI mode-0 byte shifter: CLK_DIV clocks low + CLK_DIV clocks high per bit, MSB first,
// full duplex; byte_done pulses once the eighth falling edge has been driven.
module spi_byte_shifter #(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] byte_out,
    input  logic       miso,
    output logic [7:0] byte_in,
    output logic       byte_done,
    output logic       sclk,
    output logic       mosi
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0] div_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    tx_sr;
    logic          active;
    logic          phase_high;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt    <= '0;
            bit_cnt    <= '0;
            tx_sr      <= '0;
            active     <= 1'b0;
            phase_high <= 1'b0;
            byte_in    <= '0;
            byte_done  <= 1'b0;
            sclk       <= 1'b0;
            mosi       <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            if (!active) begin
                if (load) begin
                    active     <= 1'b1;
                    tx_sr      <= byte_out;
                    mosi       <= byte_out[7];
                    div_cnt    <= '0;
                    bit_cnt    <= '0;
                    phase_high <= 1'b0;
                end
            end else if (div_cnt == DW'(CLK_DIV - 1)) begin
                div_cnt <= '0;
                if (!phase_high) begin
                    // miso is sampled on the same edge that raises flash_clk
                    sclk       <= 1'b1;
                    phase_high <= 1'b1;
                    byte_in    <= {byte_in[6:0], miso};
                end else begin
                    sclk       <= 1'b0;
                    phase_high <= 1'b0;
                    if (bit_cnt == 3'd7) begin
                        active    <= 1'b0;
                        byte_done <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 3'd1;
                        tx_sr   <= {tx_sr[6:0], 1'b0};
                        mosi    <= tx_sr[6];
                    end
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_flash_page_writer.sv
// SPI flash programmer: WREN, Page Program (or Sector Erase with FLASH_WRITER_ERASE_EN),
// then Read Status polling until WIP clears. The FSM sequences bytes and chip select only.
module spi_flash_page_writer
    import flash_writer_pkg::*;
#(
    parameter int CLK_DIV  = 2,
    parameter int CS_GAP   = 4,
    parameter int POLL_MAX = 2000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        erase,
    input  logic [23:0] address,
    input  logic [8:0]  length,
    input  logic [7:0]  data_in,
    input  logic        data_valid,
    output logic        data_ready,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        flash_clk,
    output logic        flash_mosi,
    input  logic        flash_miso,
    output logic        flash_cs
);

    state_t      state, gap_next;
    logic [23:0] addr_q;
    logic [8:0]  len_q;
    logic [8:0]  byte_cnt;
    logic [1:0]  addr_idx;
    logic [31:0] gap_cnt;
    logic [31:0] poll_cnt;
    logic        op_erase;
    logic        pending;
    logic        erase_req;
    logic        start_ok;
    logic        sh_load;
    logic [7:0]  sh_byte;
    logic [7:0]  rx_byte;
    logic        byte_done;
    logic        unused_rx;

`ifdef FLASH_WRITER_ERASE_EN
    assign erase_req = erase;
`else
    logic unused_erase;
    assign erase_req    = 1'b0;
    assign unused_erase = erase;
`endif

    assign unused_rx = ^rx_byte[7:1];

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        sh_byte = 8'h00;
        sh_load = 1'b0;
        case (state)
            S_WREN:      sh_byte = OP_WREN;
            S_CMD:       sh_byte = op_erase ? OP_SE : OP_PP;
            S_ADDR:      sh_byte = (addr_idx == 2'd0) ? addr_q[23:16] :
                                   (addr_idx == 2'd1) ? addr_q[15:8]  : addr_q[7:0];
            S_DATA:      sh_byte = data_in;
            S_RDSR_CMD:  sh_byte = OP_RDSR;
            default:     sh_byte = 8'h00;
        endcase
        case (state)
            S_WREN, S_CMD, S_ADDR, S_RDSR_CMD, S_RDSR_READ: sh_load = !pending;
            S_DATA:                                         sh_load = !pending && data_valid;
            default:                                        sh_load = 1'b0;
        endcase
    end

    assign data_ready = (state == S_DATA) && sh_load;
    assign start_ok   = erase_req || page_fits(address[7:0], length);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            gap_next <= S_IDLE;
            addr_q   <= '0;
            len_q    <= '0;
            byte_cnt <= '0;
            addr_idx <= '0;
            gap_cnt  <= '0;
            poll_cnt <= '0;
            op_erase <= 1'b0;
            pending  <= 1'b0;
            flash_cs <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            if (sh_load)   pending <= 1'b1;
            if (byte_done) pending <= 1'b0;

            case (state)
                S_IDLE: if (start) begin
                    if (start_ok) begin
                        addr_q   <= erase_req ? {address[23:12], 12'h000} : address;
                        len_q    <= length;
                        op_erase <= erase_req;
                        busy     <= 1'b1;
                        flash_cs <= 1'b0;
                        state    <= S_WREN;
                    end else begin
                        error <= 1'b1;
                    end
                end
                S_WREN: if (byte_done) begin
                    flash_cs <= 1'b1;
                    gap_cnt  <= '0;
                    gap_next <= S_CMD;
                    state    <= S_GAP;
                end
                S_GAP: begin
                    if (gap_cnt == 32'(CS_GAP - 1)) begin
                        flash_cs <= 1'b0;
                        state    <= gap_next;
                    end else begin
                        gap_cnt <= gap_cnt + 32'd1;
                    end
                end
                S_CMD: if (byte_done) begin
                    addr_idx <= '0;
                    state    <= S_ADDR;
                end
                S_ADDR: if (byte_done) begin
                    if (addr_idx != 2'd2) begin
                        addr_idx <= addr_idx + 2'd1;
                    end else if (op_erase) begin
                        flash_cs <= 1'b1;
                        gap_cnt  <= '0;
                        gap_next <= S_RDSR_CMD;
                        state    <= S_GAP;
                    end else begin
                        byte_cnt <= '0;
                        state    <= S_DATA;
                    end
                end
                S_DATA: if (byte_done) begin
                    if (byte_cnt + 9'd1 == len_q) begin
                        flash_cs <= 1'b1;
                        gap_cnt  <= '0;
                        gap_next <= S_RDSR_CMD;
                        state    <= S_GAP;
                    end else begin
                        byte_cnt <= byte_cnt + 9'd1;
                    end
                end
                S_RDSR_CMD: if (byte_done) begin
                    poll_cnt <= '0;
                    state    <= S_RDSR_READ;
                end
                S_RDSR_READ: if (byte_done) begin
                    // cs stays low across polls; the flash streams status continuously
                    if (!rx_byte[0]) begin
                        flash_cs <= 1'b1;
                        state    <= S_DONE;
                    end else if (poll_cnt == 32'(POLL_MAX - 1)) begin
                        flash_cs <= 1'b1;
                        error    <= 1'b1;
                        busy     <= 1'b0;
                        state    <= S_IDLE;
                    end else begin
                        poll_cnt <= poll_cnt + 32'd1;
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    spi_byte_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
        .clk       (clk),
        .rst       (rst),
        .load      (sh_load),
        .byte_out  (sh_byte),
        .miso      (flash_miso),
        .byte_in   (rx_byte),
        .byte_done (byte_done),
        .sclk      (flash_clk),
        .mosi      (flash_mosi)
    );

endmodule

// File: tb/tb_spi_flash_page_writer.sv
// Bench for spi_flash_page_writer with a behavioural SPI flash model and a pin-byte scoreboard.
// Define FLASH_WRITER_ERASE_EN for both bench and RTL to include the sector-erase scenario.
module tb_spi_flash_page_writer;

    localparam int CLK_DIV  = 2;
    localparam int CS_GAP   = 4;
    localparam int POLL_MAX = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, erase, data_valid, miso_r;
    logic [23:0] address;
    logic [8:0]  length;
    logic [7:0]  data_in;
    logic        data_ready, busy, done, error, flash_clk, flash_mosi, flash_cs;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    spi_flash_page_writer #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP), .POLL_MAX(POLL_MAX)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .erase      (erase),
        .address    (address),
        .length     (length),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .flash_clk  (flash_clk),
        .flash_mosi (flash_mosi),
        .flash_miso (miso_r),
        .flash_cs   (flash_cs)
    );

    // ---------------- flash model + scoreboard ----------------
    logic [7:0]  mem [int];
    logic [8:0]  exp_q [$];      // {first byte of a cs window, byte}
    logic [8:0]  exp_e;
    logic [7:0]  src_q [$];
    bit          sb_en = 1'b1;
    logic [7:0]  m_sh = 8'h00, m_op = 8'h00, m_status = 8'h00, m_off;
    logic [23:0] m_addr = '0;
    bit          m_wel = 1'b0;
    int          m_bit = 0, m_idx = 0;
    int          wip_left = 0, wip_cfg = 0;
    int          status_reads = 0, cs_falls = 0;
    int          done_cnt = 0, error_cnt = 0, both_cnt = 0;

    always @(negedge flash_cs) begin
        cs_falls++;
        m_bit = 0;
        m_idx = 0;
    end

    always @(posedge flash_cs) begin
        if (m_op == 8'h02 && m_idx >= 4 && m_wel) begin
            wip_left = wip_cfg;
            m_wel    = 1'b0;
        end else if (m_op == 8'h20 && m_idx == 4 && m_wel) begin
            int keys [$];
            foreach (mem[k]) if (k[23:12] == int'(m_addr[23:12])) keys.push_back(k);
            foreach (keys[i]) mem.delete(keys[i]);
            wip_left = wip_cfg;
            m_wel    = 1'b0;
        end
    end

    always @(posedge flash_clk) begin
        if (flash_cs === 1'b0) begin
            m_sh = {m_sh[6:0], flash_mosi};
            m_bit++;
            if (m_bit == 8) begin
                m_bit = 0;
                if (sb_en) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL pin_byte: got %h, no byte expected", m_sh);
                    end else begin
                        exp_e = exp_q.pop_front();
                        if ({m_idx == 0, m_sh} !== exp_e) begin
                            failures++;
                            $display("FAIL pin_byte: got first=%0d %h, expected first=%0d %h",
                                     m_idx == 0, m_sh, exp_e[8], exp_e[7:0]);
                        end
                    end
                end
                if (m_idx == 0) begin
                    m_op = m_sh;
                    if (m_sh == 8'h06) m_wel = 1'b1;
                end else if ((m_op == 8'h02 || m_op == 8'h20) && m_idx <= 3) begin
                    m_addr = {m_addr[15:0], m_sh};
                end else if (m_op == 8'h02 && m_wel) begin
                    m_off = m_addr[7:0] + 8'(m_idx - 4);
                    mem[int'({m_addr[23:8], m_off})] = m_sh;
                end else if (m_op == 8'h05) begin
                    status_reads++;
                end
                m_idx++;
            end
        end
    end

    always @(negedge flash_clk) begin
        if (flash_cs === 1'b0 && m_op == 8'h05 && m_idx >= 1) begin
            if (m_bit == 0) begin
                m_status = {7'b0, wip_left > 0};
                if (wip_left > 0) wip_left--;
            end
            miso_r = m_status[7 - m_bit];
        end
    end

    always @(negedge clk) begin
        if (done === 1'b1)                   done_cnt++;
        if (error === 1'b1)                  error_cnt++;
        if (done === 1'b1 && error === 1'b1) both_cnt++;
    end

    // ---------------- helpers ----------------
    function automatic logic [7:0] rd(input logic [23:0] a);
        return mem.exists(int'(a)) ? mem[int'(a)] : 8'hFF;
    endfunction

    function automatic int mem_errors(input logic [23:0] base);
        int e = 0;
        foreach (src_q[i]) if (rd(base + 24'(i)) !== src_q[i]) e++;
        return e;
    endfunction

    task automatic expect_program(input logic [23:0] a, input int polls);
        exp_q.push_back({1'b1, 8'h06});
        exp_q.push_back({1'b1, 8'h02});
        exp_q.push_back({1'b0, a[23:16]});
        exp_q.push_back({1'b0, a[15:8]});
        exp_q.push_back({1'b0, a[7:0]});
        foreach (src_q[i]) exp_q.push_back({1'b0, src_q[i]});
        exp_q.push_back({1'b1, 8'h05});
        repeat (polls) exp_q.push_back({1'b0, 8'h00});
    endtask

    task automatic run_op(input logic [23:0] a, input logic [8:0] len, input bit er,
                          input int pause_after, output int n_ready, output bit got_done,
                          output bit got_err, output bit frozen_ok, output bit busy_end);
        int idx = 0, cyc = 0, pause = 0;
        n_ready = 0; got_done = 0; got_err = 0; frozen_ok = 1; busy_end = 1;
        @(negedge clk);
        address = a; length = len; erase = er; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!got_done && !got_err && cyc < 30000) begin
            if (pause_after >= 0 && idx == pause_after && pause < 100) begin
                data_valid = 1'b0;
                pause++;
                if (pause > 40 && (flash_clk !== 1'b0 || flash_cs !== 1'b0)) frozen_ok = 0;
            end else if (idx < src_q.size()) begin
                data_valid = 1'b1;
                data_in    = src_q[idx];
            end else begin
                data_valid = 1'b0;
            end
            #1;
            if (data_valid && data_ready === 1'b1) begin idx++; n_ready++; end
            if (done === 1'b1)  got_done = 1;
            if (error === 1'b1) got_err  = 1;
            if (got_done || got_err) busy_end = busy;
            @(negedge clk);
            cyc++;
        end
        data_valid = 1'b0;
        erase      = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({flash_cs, flash_clk, flash_mosi} !== 3'b100) begin
            failures++;
            $display("FAIL reset_pins: got cs/clk/mosi=%b, expected 100", {flash_cs, flash_clk, flash_mosi});
        end
        checks++;
        if ({busy, done, error, data_ready} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_status: got busy/done/error/ready=%b, expected 0000", {busy, done, error, data_ready});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_program();
        int n, d0; bit d, e, f, b;
        src_q = '{8'h31, 8'h32, 8'h33, 8'h34};
        expect_program(24'h000100, 1);
        d0 = done_cnt;
        run_op(24'h000100, 9'd4, 1'b0, -1, n, d, e, f, b);
        repeat (4) @(negedge clk);
        checks++; if ({d, e} !== 2'b10) begin failures++; $display("FAIL prog_done: got done=%0d err=%0d, expected 1 0", d, e); end
        checks++; if (n != 4) begin failures++; $display("FAIL prog_ready: got %0d, expected 4", n); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL prog_pins_left: got %0d unsent, expected 0", exp_q.size()); end
        checks++;
        if ({rd(24'h103), rd(24'h102), rd(24'h101), rd(24'h100)} !== 32'h3433_3231) begin
            failures++;
            $display("FAIL prog_mem: got %h, expected 34333231", {rd(24'h103), rd(24'h102), rd(24'h101), rd(24'h100)});
        end
        checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL prog_done_pulses: got %0d, expected 1", done_cnt - d0); end
        checks++; if (b !== 1'b0) begin failures++; $display("FAIL prog_busy_drop: got busy=%b with done, expected 0", b); end
    endtask

    task automatic test_wip_polls();
        int n, s0, c0; bit d, e, f, b;
        wip_cfg = 3;
        src_q = '{8'hAA, 8'h55};
        expect_program(24'h000200, 4);
        s0 = status_reads; c0 = cs_falls;
        run_op(24'h000200, 9'd2, 1'b0, -1, n, d, e, f, b);
        checks++; if (d !== 1'b1) begin failures++; $display("FAIL wip_done: got %0d, expected 1", d); end
        checks++; if (status_reads - s0 != 4) begin failures++; $display("FAIL wip_status_bytes: got %0d, expected 4", status_reads - s0); end
        checks++; if (cs_falls - c0 != 3) begin failures++; $display("FAIL wip_cs_windows: got %0d, expected 3", cs_falls - c0); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL wip_pins_left: got %0d, expected 0", exp_q.size()); end
        wip_cfg = 0;
    endtask

    task automatic test_reject();
        logic [23:0] bad_a [3] = '{24'h0000F0, 24'h000000, 24'h000000};
        logic [8:0]  bad_l [3] = '{9'd32, 9'd0, 9'd257};
        int n, c0; bit d, e, f, b;
        for (int i = 0; i < 3; i++) begin
            c0 = cs_falls;
            @(negedge clk);
            address = bad_a[i]; length = bad_l[i]; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            checks++;
            if ({error, busy} !== 2'b10) begin
                failures++;
                $display("FAIL reject_%0d_pulse: got error/busy=%b, expected 10", i, {error, busy});
            end
            repeat (20) @(negedge clk);
            checks++;
            if (cs_falls != c0 || flash_cs !== 1'b1) begin
                failures++;
                $display("FAIL reject_%0d_cs: got %0d cs falls, cs=%b, expected 0 and 1", i, cs_falls - c0, flash_cs);
            end
        end
        // exact fit to the end of a page is legal
        src_q = '{8'hC0, 8'hC1, 8'hC2, 8'hC3};
        expect_program(24'h0003FC, 1);
        run_op(24'h0003FC, 9'd4, 1'b0, -1, n, d, e, f, b);
        checks++; if ({d, e} !== 2'b10) begin failures++; $display("FAIL page_end_done: got done=%0d err=%0d, expected 1 0", d, e); end
        checks++; if (mem_errors(24'h0003FC) != 0) begin failures++; $display("FAIL page_end_mem: got %0d bad bytes, expected 0", mem_errors(24'h0003FC)); end
    endtask

    task automatic test_full_page();
        int n; bit d, e, f, b;
        src_q.delete();
        for (int i = 0; i < 256; i++) src_q.push_back(8'(i) ^ 8'h5A);
        expect_program(24'h000000, 1);
        run_op(24'h000000, 9'd256, 1'b0, -1, n, d, e, f, b);
        checks++; if (n != 256) begin failures++; $display("FAIL page_ready: got %0d, expected 256", n); end
        checks++; if (d !== 1'b1) begin failures++; $display("FAIL page_done: got %0d, expected 1", d); end
        checks++; if (mem_errors(24'h000000) != 0) begin failures++; $display("FAIL page_mem: got %0d bad bytes, expected 0", mem_errors(24'h000000)); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL page_pins_left: got %0d, expected 0", exp_q.size()); end
    endtask

    task automatic test_stall();
        int n; bit d, e, f, b;
        src_q.delete();
        for (int i = 0; i < 32; i++) src_q.push_back(8'(8'hA0 + i));
        expect_program(24'h000400, 1);
        run_op(24'h000400, 9'd32, 1'b0, 10, n, d, e, f, b);
        checks++; if (f !== 1'b1) begin failures++; $display("FAIL stall_frozen: got %0d, expected clk low and cs low (1)", f); end
        checks++; if ({d, n} !== {1'b1, 32'd32}) begin failures++; $display("FAIL stall_done: got done=%0d ready=%0d, expected 1 32", d, n); end
        checks++; if (mem_errors(24'h000400) != 0) begin failures++; $display("FAIL stall_mem: got %0d bad bytes, expected 0", mem_errors(24'h000400)); end
    endtask

    task automatic test_timeout();
        int n, s0; bit d, e, f, b;
        wip_cfg = 100;
        src_q = '{8'h77};
        expect_program(24'h000700, POLL_MAX);
        s0 = status_reads;
        run_op(24'h000700, 9'd1, 1'b0, -1, n, d, e, f, b);
        checks++; if ({d, e, b} !== 3'b010) begin failures++; $display("FAIL timeout_err: got done/err/busy=%b, expected 010", {d, e, b}); end
        checks++; if (status_reads - s0 != POLL_MAX) begin failures++; $display("FAIL timeout_polls: got %0d, expected %0d", status_reads - s0, POLL_MAX); end
        checks++; if (exp_q.size() != 0 || flash_cs !== 1'b1) begin failures++; $display("FAIL timeout_end: got %0d left, cs=%b, expected 0 and 1", exp_q.size(), flash_cs); end
        wip_cfg = 0; wip_left = 0;
    endtask

    task automatic test_reset_mid();
        int n, cyc = 0, rcnt = 0; bit d, e, f, b;
        sb_en = 1'b0;
        src_q.delete();
        for (int i = 0; i < 16; i++) src_q.push_back(8'(i));
        @(negedge clk);
        address = 24'h000500; length = 9'd16; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (rcnt < 3 && cyc < 5000) begin
            data_valid = 1'b1; data_in = src_q[rcnt];
            #1;
            if (data_ready === 1'b1) rcnt++;
            if (rcnt < 3) begin @(negedge clk); cyc++; end
        end
        checks++;
        if (rcnt != 3) begin failures++; $display("FAIL rst_mid_reach_data: got %0d bytes, expected 3", rcnt); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({flash_cs, flash_clk, busy} !== 3'b100) begin
            failures++;
            $display("FAIL rst_mid_async: got cs/clk/busy=%b, expected 100", {flash_cs, flash_clk, busy});
        end
        data_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete(); wip_left = 0; sb_en = 1'b1;
        src_q = '{8'hE1, 8'hE2, 8'hE3, 8'hE4};
        expect_program(24'h000600, 1);
        run_op(24'h000600, 9'd4, 1'b0, -1, n, d, e, f, b);
        checks++; if ({d, e} !== 2'b10) begin failures++; $display("FAIL rst_mid_rerun: got done=%0d err=%0d, expected 1 0", d, e); end
        checks++; if (mem_errors(24'h000600) != 0 || exp_q.size() != 0) begin failures++; $display("FAIL rst_mid_rerun_data: got %0d bad, %0d left, expected 0 0", mem_errors(24'h000600), exp_q.size()); end
    endtask

`ifdef FLASH_WRITER_ERASE_EN
    task automatic test_erase();
        int n; bit d, e, f, b;
        mem[int'(24'h012345)] = 8'h00;
        src_q.delete();
        exp_q.push_back({1'b1, 8'h06});
        exp_q.push_back({1'b1, 8'h20});
        exp_q.push_back({1'b0, 8'h01});
        exp_q.push_back({1'b0, 8'h20});
        exp_q.push_back({1'b0, 8'h00});
        exp_q.push_back({1'b1, 8'h05});
        exp_q.push_back({1'b0, 8'h00});
        run_op(24'h012345, 9'd0, 1'b1, -1, n, d, e, f, b);
        checks++; if ({d, e} !== 2'b10) begin failures++; $display("FAIL erase_done: got done=%0d err=%0d, expected 1 0", d, e); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL erase_pins_left: got %0d, expected 0", exp_q.size()); end
        checks++; if (rd(24'h012345) !== 8'hFF) begin failures++; $display("FAIL erase_mem: got %h, expected ff", rd(24'h012345)); end
    endtask
`endif

    initial begin
        rst = 1'b1;
        start = 1'b0; erase = 1'b0; data_valid = 1'b0; data_in = 8'h00;
        address = '0; length = '0; miso_r = 1'b0;
        test_reset();
        test_program();
        test_wip_polls();
        test_reject();
        test_full_page();
        test_stall();
        test_timeout();
        test_reset_mid();
`ifdef FLASH_WRITER_ERASE_EN
        test_erase();
`endif
        checks++;
        if (both_cnt != 0) begin failures++; $display("FAIL done_error_overlap: got %0d cycles, expected 0", both_cnt); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
